// File: rtl/uart_tx_drain.sv
// Drain stage between the outbound FWFT byte FIFO and the UART transmitter.
// Optional XON/XOFF launch gating is compiled in when UART_TX_DRAIN_XONXOFF_EN is defined.
module uart_tx_drain #(
  parameter int GAP_CYCLES   = 4095,
  parameter int BUSY_TIMEOUT = 4,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [7:0]             fifo_data,
  output logic                   fifo_read,
  output logic [7:0]             tx_byte,
  output logic                   transmit,
  input  logic                   tx_busy,
`ifdef UART_TX_DRAIN_XONXOFF_EN
  input  logic                   rx_received,
  input  logic [7:0]             rx_byte,
`endif
  output logic                   idle,
  output logic [COUNT_WIDTH-1:0] sent_count
);

  // state    | meaning
  // IDLE     | waiting for enable, FIFO data and a quiet UART
  // WAITBUSY | strobe issued, waiting (bounded) for tx_busy to rise
  // WAITDONE | waiting for tx_busy to fall
  // GAP      | counting down the inter-byte gap
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAITBUSY = 2'd1,
    WAITDONE = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TO_LOAD  = TW'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);

  state_t                 state_q, state_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [TW-1:0]          to_q, to_d;
  logic [7:0]             tx_byte_d;
  logic [COUNT_WIDTH-1:0] sent_count_d;
  logic                   fifo_read_d;
  logic                   transmit_d;
  logic                   idle_d;
  logic                   paused;
  logic                   launch_ok;

`ifdef UART_TX_DRAIN_XONXOFF_EN
  logic paused_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      paused_q <= 1'b0;
    end else if (rx_received) begin
      if (rx_byte == 8'h13)
        paused_q <= 1'b1;
      else if (rx_byte == 8'h11)
        paused_q <= 1'b0;
    end
  end

  assign paused = paused_q;
`else
  assign paused = 1'b0;
`endif

  assign launch_ok = enable && !fifo_empty && !tx_busy && !paused;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      to_q       <= '0;
      tx_byte    <= 8'h00;
      sent_count <= '0;
      fifo_read  <= 1'b0;
      transmit   <= 1'b0;
      idle       <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      to_q       <= to_d;
      tx_byte    <= tx_byte_d;
      sent_count <= sent_count_d;
      fifo_read  <= fifo_read_d;
      transmit   <= transmit_d;
      idle       <= idle_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    to_d         = to_q;
    tx_byte_d    = tx_byte;
    sent_count_d = sent_count;
    fifo_read_d  = 1'b0;
    transmit_d   = 1'b0;
    idle_d       = (state_q == IDLE) && fifo_empty;

    case (state_q)
      IDLE: begin
        if (launch_ok) begin
          tx_byte_d    = fifo_data;
          fifo_read_d  = 1'b1;
          transmit_d   = 1'b1;
          sent_count_d = sent_count + COUNT_WIDTH'(1);
          to_d         = TO_LOAD;
          state_d      = WAITBUSY;
        end
      end
      // FIFO flags are ignored here so the post-pop update has settled by IDLE.
      WAITBUSY: begin
        if (tx_busy || to_q == '0)
          state_d = WAITDONE;
        else
          to_d = to_q - TW'(1);
      end
      WAITDONE: begin
        if (!tx_busy) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == '0)
          state_d = IDLE;
        else
          gap_d = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench for uart_tx_drain: FIFO/UART models plus a spacing/order/count reference.
// Set UART_TX_DRAIN_XONXOFF_EN to also exercise the XON/XOFF gate.
module tb_uart_tx_drain;
  localparam int GAP = 10;
  localparam int TO  = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          fifo_empty;
  logic [7:0]    fifo_data;
  logic          fifo_read;
  logic [7:0]    tx_byte;
  logic          transmit;
  logic          tx_busy;
  logic          idle;
  logic [CW-1:0] sent_count;
  logic          rx_received;
  logic [7:0]    rx_byte;

  uart_tx_drain #(
    .GAP_CYCLES  (GAP),
    .BUSY_TIMEOUT(TO),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .tx_byte    (tx_byte),
    .transmit   (transmit),
    .tx_busy    (tx_busy),
`ifdef UART_TX_DRAIN_XONXOFF_EN
    .rx_received(rx_received),
    .rx_byte    (rx_byte),
`endif
    .idle       (idle),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       push;
    logic [7:0] data;
    logic       exp_idle;
    logic       exp_tx;
  } vec_t;

  vec_t vecs[4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobes = 0;
  int last_strobe = 0;
  int exp_next = 0;
  int exp_count = 0;
  int rise_at = 0;
  int fall_at = 0;
  int u_d = 0;
  int u_f = 10;
  bit have_prev = 0;
  bit chk_spacing = 0;
  bit prev_tx = 0;
  bit rnd_uart = 0;
  bit u_never = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
    fifo_data  = fifo_q[0];
  endtask

  // One clock: observe DUT at the falling edge, then advance the FIFO and UART models.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (transmit) begin
      check("no_back_to_back", prev_tx, 0);
      check("pop_with_strobe", fifo_read, 1);
      check("strobe_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("tx_byte_order", tx_byte, exp_q.pop_front());
      exp_count = (exp_count + 1) % (1 << CW);
      check("sent_count", sent_count, exp_count);
      if (chk_spacing && have_prev)
        check("strobe_spacing", cyc - last_strobe, exp_next - last_strobe);
      if (rnd_uart) begin
        u_never = ($urandom_range(0, 7) == 0);
        u_d     = $urandom_range(0, 3);
        u_f     = $urandom_range(1, 30);
      end
      if (u_never) begin
        rise_at  = 0;
        fall_at  = 0;
        exp_next = cyc + TO + GAP + 2;
      end else begin
        rise_at  = cyc + u_d;
        fall_at  = rise_at + u_f;
        exp_next = fall_at + GAP + 2;
      end
      last_strobe = cyc;
      have_prev   = 1;
      strobes++;
    end else if (fifo_read) begin
      check("pop_without_strobe", fifo_read, 0);
    end
    prev_tx = transmit;
    if (fifo_read && fifo_q.size() > 0) void'(fifo_q.pop_front());
    tx_busy    = (cyc >= rise_at) && (cyc < fall_at);
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic wait_strobes(input int n, input int budget, input string name);
    int k = 0;
    while (strobes < n && k < budget) begin
      tick();
      k++;
    end
    check(name, strobes >= n, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (!(idle && fifo_q.size() == 0 && !tx_busy) && k < budget) begin
      tick();
      k++;
    end
    check(name, idle && fifo_q.size() == 0, 1);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic apply_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_fifo_read", fifo_read, 0);
    check("rst_transmit", transmit, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_sent_count", sent_count, 0);
    check("rst_idle", idle, 0);
    exp_count = 0;
    have_prev = 0;
    prev_tx   = 0;
    tick();
    tick();
    #2 reset_n = 1'b1;
  endtask

  initial begin
    int s0;
    reset_n     = 1'b0;
    enable      = 1'b0;
    fifo_empty  = 1'b1;
    fifo_data   = 8'h00;
    tx_busy     = 1'b0;
    rx_received = 1'b0;
    rx_byte     = 8'h00;

    vecs[0] = '{en: 1'b0, push: 1'b0, data: 8'h00, exp_idle: 1'b1, exp_tx: 1'b0};
    vecs[1] = '{en: 1'b1, push: 1'b0, data: 8'h00, exp_idle: 1'b1, exp_tx: 1'b0};
    vecs[2] = '{en: 1'b0, push: 1'b1, data: 8'h5A, exp_idle: 1'b0, exp_tx: 1'b0};
    vecs[3] = '{en: 1'b1, push: 1'b0, data: 8'h00, exp_idle: 1'b0, exp_tx: 1'b1};

    // Reset values and single-step launch behaviour
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      enable = vecs[i].en;
      if (vecs[i].push) push(vecs[i].data);
      tick();
      check($sformatf("vec%0d_idle", i), idle, vecs[i].exp_idle);
      check($sformatf("vec%0d_transmit", i), transmit, vecs[i].exp_tx);
    end
    wait_idle(200, "vec_drain_idle");

    // Two bytes, 100-clock frames
    apply_reset();
    have_prev = 0; chk_spacing = 1; u_never = 0; u_d = 0; u_f = 100;
    push(8'h41);
    push(8'h42);
    s0 = strobes;
    enable = 1'b1;
    wait_strobes(s0 + 2, 400, "plan_two_strobes");
    wait_idle(300, "plan_idle");
    check("plan_strobe_total", strobes - s0, 2);
    check("plan_sent_count", sent_count, 2);
    check("plan_idle_end", idle, 1);

    // UART never raises busy: timeout path
    have_prev = 0; u_never = 1;
    push(8'hB1); push(8'hB2); push(8'hB3);
    s0 = strobes;
    wait_strobes(s0 + 3, 200, "timeout_strobes");
    wait_idle(100, "timeout_idle");
    u_never = 0;

    // enable dropped mid-byte
    have_prev = 0; chk_spacing = 0; u_d = 0; u_f = 40;
    push(8'hA1); push(8'hA2); push(8'hA3);
    s0 = strobes;
    wait_strobes(s0 + 1, 50, "endrop_first");
    repeat (20) tick();
    enable = 1'b0;
    repeat (150) tick();
    check("endrop_hold", strobes, s0 + 1);
    check("endrop_not_idle", idle, 0);
    enable = 1'b1;
    wait_strobes(s0 + 3, 300, "endrop_resume");
    wait_idle(200, "endrop_idle");

    // Reset in WAITDONE; remaining bytes still go out, count restarts
    have_prev = 0; chk_spacing = 1; u_d = 0; u_f = 60;
    push(8'hC1); push(8'hC2); push(8'hC3);
    s0 = strobes;
    wait_strobes(s0 + 1, 50, "rst_mid_first");
    repeat (20) tick();
    apply_reset();
    wait_strobes(s0 + 2, 200, "rst_mid_second");
    check("rst_count_restart", sent_count, 1);
    wait_strobes(s0 + 3, 200, "rst_mid_third");
    wait_idle(200, "rst_mid_idle");

`ifdef UART_TX_DRAIN_XONXOFF_EN
    // XOFF mid-stream, then XON
    have_prev = 0; chk_spacing = 0; u_d = 0; u_f = 20;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    s0 = strobes;
    wait_strobes(s0 + 1, 50, "xoff_first");
    repeat (5) tick();
    rx_byte = 8'h13; rx_received = 1'b1; tick(); rx_received = 1'b0;
    repeat (100) tick();
    check("xoff_hold", strobes, s0 + 1);
    rx_byte = 8'h41; rx_received = 1'b1; tick(); rx_received = 1'b0;
    repeat (20) tick();
    check("xoff_other_byte", strobes, s0 + 1);
    rx_byte = 8'h11; rx_received = 1'b1; tick(); rx_received = 1'b0;
    wait_strobes(s0 + 2, GAP + 2, "xon_resume");
    wait_idle(400, "xon_idle");
`endif

    // Randomized frames and data, 17 bytes so the 4-bit count wraps
    apply_reset();
    have_prev = 0; chk_spacing = 1; rnd_uart = 1;
    for (int i = 0; i < 17; i++) push(8'($urandom_range(0, 255)));
    s0 = strobes;
    wait_strobes(s0 + 17, 3000, "rand_strobes");
    wait_idle(200, "rand_idle");
    check("wrap_sent_count", sent_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
